// File: rtl/regfile_pkg.sv
// Shared types and helpers for the async multi-port register file.
// Handshake state encoding and address range check.
package regfile_pkg;

   typedef enum logic {
      HS_IDLE = 1'b0,
      HS_ACK  = 1'b1
   } hs_state_t;

   function automatic logic addr_valid(
      input int unsigned addr,
      input int unsigned nregs
   );
      return addr < nregs;
   endfunction

endpackage

// File: rtl/hs_slave.sv
// Four-phase req/ack slave, one per register file port.
// accept pulses on the edge where a new request is taken.
module hs_slave
   import regfile_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req,
   output logic ack,
   output logic accept
);

   hs_state_t state;
   hs_state_t state_nxt;

   // state register, synchronous reset back to idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HS_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state; accept only leaving idle
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      unique case (state)
         HS_IDLE: begin
            if (req) begin
               accept    = 1'b1;
               state_nxt = HS_ACK;
            end
         end
         HS_ACK: begin
            if (!req) begin
               state_nxt = HS_IDLE;
            end
         end
         default: state_nxt = HS_IDLE;
      endcase
   end

   assign ack = (state == HS_ACK);

endmodule

// File: rtl/async_regfile_mp.sv
// Multi-port register file with per-port four-phase handshakes.
// Write-first forwarding, optional hardwired r0, range protection.
module async_regfile_mp
   import regfile_pkg::*;
#(
   parameter int DataWidth    = 16,
   parameter int NumRegs      = 16,
   parameter int AddrWidth    = 4,
   parameter int NumReadPorts = 2,
   parameter int ZeroReg      = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr_req,
   output logic                              wr_ack,
   input  logic [AddrWidth-1:0]              wr_addr,
   input  logic [DataWidth-1:0]              wr_data,
   input  logic [NumReadPorts-1:0]           rd_req,
   output logic [NumReadPorts-1:0]           rd_ack,
   input  logic [NumReadPorts*AddrWidth-1:0] rd_addr,
   output logic [NumReadPorts*DataWidth-1:0] rd_data,
   output logic                              addr_err
);

   logic [DataWidth-1:0] regs [NumRegs];

   logic                    wr_acc;
   logic [NumReadPorts-1:0] rd_acc;

   logic wr_inr;
   logic wr_ok;

   logic [AddrWidth-1:0] rd_a   [NumReadPorts];
   logic [DataWidth-1:0] rd_nxt [NumReadPorts];
   logic [DataWidth-1:0] rd_q   [NumReadPorts];

   logic err_nxt;
   logic err_q;

   hs_slave u_wr_hs (
      .clk    (clk),
      .rst    (rst),
      .req    (wr_req),
      .ack    (wr_ack),
      .accept (wr_acc)
   );

   for (genvar i = 0; i < NumReadPorts; i++) begin : g_rd
      hs_slave u_rd_hs (
         .clk    (clk),
         .rst    (rst),
         .req    (rd_req[i]),
         .ack    (rd_ack[i]),
         .accept (rd_acc[i])
      );
      assign rd_a[i] = rd_addr[i*AddrWidth +: AddrWidth];
      assign rd_data[i*DataWidth +: DataWidth] = rd_q[i];
   end

   // write qualification: in range and not the hardwired zero register
   always_comb begin
      wr_inr = addr_valid(32'(wr_addr), NumRegs);
      wr_ok  = wr_inr;
      if ((ZeroReg != 0) && (wr_addr == '0)) begin
         wr_ok = 1'b0;
      end
   end

   // read data select with write-first forwarding, plus error detect
   always_comb begin
      err_nxt = wr_acc && !wr_inr;
      for (int i = 0; i < NumReadPorts; i++) begin
         rd_nxt[i] = '0;
         if (!addr_valid(32'(rd_a[i]), NumRegs)) begin
            rd_nxt[i] = '0;
            if (rd_acc[i]) begin
               err_nxt = 1'b1;
            end
         end else if ((ZeroReg != 0) && (rd_a[i] == '0)) begin
            rd_nxt[i] = '0;
         end else if (wr_acc && wr_ok && (rd_a[i] == wr_addr)) begin
            rd_nxt[i] = wr_data;
         end else begin
            rd_nxt[i] = regs[rd_a[i]];
         end
      end
   end

   // register array, written only by a qualified accepted write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NumRegs; r++) begin
            regs[r] <= '0;
         end
      end else if (wr_acc && wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // per-port read data, loaded on accept and held otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NumReadPorts; i++) begin
            rd_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NumReadPorts; i++) begin
            if (rd_acc[i]) begin
               rd_q[i] <= rd_nxt[i];
            end
         end
      end
   end

   // one-cycle out-of-range pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_nxt;
      end
   end

   assign addr_err = err_q;

endmodule
